multi_clk_divider: RTL and testbench
====================================

MULTI_CLK_DIVIDER -- requirements
Module: multi_clk_divider

Interface
REQ-001 The block SHALL have parameter NCH, default 4, meaning the number of independent divider channels (1..16).
REQ-002 The block SHALL have parameter WIDTH, default 32, meaning the half-period count width.
REQ-003 Port clock  input  1  SHALL be the single system clock; all logic is clocked on its rising edge.
REQ-004 Port resetn  input  1  SHALL be the reset, synchronous and active-low.
REQ-005 Port en  input  NCH  SHALL be the per-channel run enable.
REQ-006 Port sync  input  1  SHALL be a one-cycle restart strobe for all enabled channels.
REQ-007 Port cfg_valid  input  1  SHALL be the config write request.
REQ-008 Port cfg_ready  output  1  SHALL be the config accept indication.
REQ-009 Port cfg_ch  input  max(1,clog2(NCH))  SHALL be the target channel index.
REQ-010 Port cfg_m  input  WIDTH  SHALL be the low-half cutoff: low phase lasts cfg_m+1 cycles.
REQ-011 Port cfg_h  input  WIDTH  SHALL be the high-half cutoff, present only with CLKDIV_DUTY_EN.
REQ-012 Port slow_clock  output  NCH  SHALL be the divided clock per channel, registered.
REQ-013 Port rise_tick  output  NCH  SHALL pulse high for one cycle on the cycle slow_clock[i] goes 0->1.

Function
REQ-014 Each channel SHALL hold active (act_m, act_h) and shadow (sh_m, sh_h) cutoffs, a WIDTH-bit counter and state IDLE/HIGH/LOW.
REQ-015 IDLE: slow_clock=0, counter=0; en[i]=1 -> HIGH next cycle with counter=0 and rise_tick=1.
REQ-016 HIGH: counter increments; at counter==act_h -> LOW, counter=0.
REQ-017 LOW: counter increments; at counter==act_m -> HIGH, counter=0, rise_tick=1 (period boundary).
REQ-018 Period SHALL be (act_h+1)+(act_m+1) cycles; all-ones cutoffs SHALL NOT overflow (counter compare precedes increment).
REQ-019 cfg_ready SHALL equal NOT pending[cfg_ch]; a transfer occurs when cfg_valid and cfg_ready are both high.
REQ-020 A transfer SHALL load the shadow of cfg_ch and set pending; cfg_ch >= NCH SHALL be accepted and discarded.
REQ-021 Pending shadow SHALL commit to active at the period boundary, or the same cycle if the channel is IDLE or en[i]=0; pending clears on commit.
REQ-022 A transfer in the same cycle as a boundary on that channel SHALL commit at the following boundary, not the current one.
REQ-023 en[i] falling SHALL force IDLE, slow_clock=0 the next cycle, regardless of phase.
REQ-024 sync=1 SHALL commit any pending shadow and restart every enabled channel in HIGH with counter=0 and rise_tick=1 next cycle; sync overrides boundary transitions.
REQ-025 Channels SHALL be mutually independent except for sync and the shared config port.

Reset
REQ-026 resetn=0 at a clock edge SHALL set all states IDLE, counters 0, slow_clock=0, rise_tick=0, pending=0, active and shadow cutoffs 0.
REQ-027 Reset mid-period SHALL abandon the period and discard pending config; after release cfg_ready=1.

Configuration
REQ-028 With CLKDIV_DUTY_EN defined, cfg_h SHALL exist and set high-phase length independently.
REQ-029 Without CLKDIV_DUTY_EN, cfg_h SHALL be absent and act_h SHALL track act_m (50% duty, period 2(m+1)).

Structure
REQ-030 Package clk_div_pkg SHALL hold the state enum (IDLE, HIGH, LOW) and the default WIDTH constant.
REQ-031 Per-channel logic SHALL be sub-module clk_div_channel, instantiated NCH times; the top holds config decode and sync fan-out.

Verification
REQ-032 Reset, en=4'b0001, m=0 (no duty) -> ch0 toggles every cycle, period 2, rise_tick every 2 cycles.
REQ-033 m=3 written while ch1 running with m=1 -> old period 4 continues until the next boundary, then period 8; cfg_ready low for ch1 until commit.
REQ-034 CLKDIV_DUTY_EN, h=0, m=4 -> high 1 cycle, low 5 cycles, repeated.
REQ-035 Channels 0 and 2 running out of phase, sync pulse -> both slow_clock high and rise_tick on the same cycle thereafter.
REQ-036 en[0] dropped mid-HIGH with config pending -> slow_clock[0]=0 next cycle, pending committed, cfg_ready high.
REQ-037 resetn asserted mid-LOW with config pending -> all outputs 0, pending cleared, cutoffs 0 after release.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the multi-channel clock divider.
// Optional feature macro used by this block: CLKDIV_DUTY_EN (independent high-phase cutoff).
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } ch_state_t;

    localparam int unsigned DEFAULT_WIDTH = 32;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: IDLE/HIGH/LOW phase counter with shadowed cutoffs.
// CLKDIV_DUTY_EN adds a separate high-phase cutoff; otherwise the high phase mirrors the low one.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_m,
`ifdef CLKDIV_DUTY_EN
    input  logic [WIDTH-1:0] wr_h,
`endif
    output logic             pending,
    output logic             slow_clock,
    output logic             rise_tick
);

    ch_state_t        state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] act_m;
    logic [WIDTH-1:0] sh_m;
    logic [WIDTH-1:0] h_cut;
    logic             commit;

`ifdef CLKDIV_DUTY_EN
    logic [WIDTH-1:0] act_h;
    logic [WIDTH-1:0] sh_h;

    always_comb h_cut = act_h;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            act_h <= '0;
            sh_h  <= '0;
        end else begin
            if (commit) act_h <= sh_h;
            if (wr)     sh_h  <= wr_h;
        end
    end
`else
    always_comb h_cut = act_m;
`endif

    // wr is only possible while pending is clear, so a write can never
    // coincide with a commit; a write on a boundary cycle waits for the next one.
    always_comb begin
        commit = pending && (!en || sync || (state == IDLE) ||
                             ((state == LOW) && (cnt == act_m)));
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state      <= IDLE;
            cnt        <= '0;
            act_m      <= '0;
            sh_m       <= '0;
            pending    <= 1'b0;
            slow_clock <= 1'b0;
            rise_tick  <= 1'b0;
        end else begin
            rise_tick <= 1'b0;
            if (commit) act_m <= sh_m;
            if (wr) begin
                sh_m    <= wr_m;
                pending <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end

            if (!en) begin
                state      <= IDLE;
                cnt        <= '0;
                slow_clock <= 1'b0;
            end else if (sync || (state == IDLE)) begin
                state      <= HIGH;
                cnt        <= '0;
                slow_clock <= 1'b1;
                rise_tick  <= 1'b1;
            end else begin
                case (state)
                    HIGH: begin
                        if (cnt == h_cut) begin
                            state      <= LOW;
                            cnt        <= '0;
                            slow_clock <= 1'b0;
                        end else begin
                            cnt <= cnt + WIDTH'(1);
                        end
                    end
                    LOW: begin
                        if (cnt == act_m) begin
                            state      <= HIGH;
                            cnt        <= '0;
                            slow_clock <= 1'b1;
                            rise_tick  <= 1'b1;
                        end else begin
                            cnt <= cnt + WIDTH'(1);
                        end
                    end
                    default: begin
                        state      <= IDLE;
                        cnt        <= '0;
                        slow_clock <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/multi_clk_divider.sv
// NCH independent clock dividers sharing one config port and a common sync strobe.
// CLKDIV_DUTY_EN adds the cfg_h port for an independent high-phase length.
module multi_clk_divider
    import clk_div_pkg::*;
#(
    parameter int unsigned NCH   = 4,
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    localparam int unsigned CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [NCH-1:0]   en,
    input  logic             sync,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CW-1:0]    cfg_ch,
    input  logic [WIDTH-1:0] cfg_m,
`ifdef CLKDIV_DUTY_EN
    input  logic [WIDTH-1:0] cfg_h,
`endif
    output logic [NCH-1:0]   slow_clock,
    output logic [NCH-1:0]   rise_tick
);

    logic [NCH-1:0] pending;
    logic           xfer;

    // Out-of-range channel indices read as ready so the write is consumed and dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (cfg_ch == CW'(i)) cfg_ready = ~pending[i];
        end
    end

    always_comb xfer = cfg_valid && cfg_ready;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        clk_div_channel #(.WIDTH(WIDTH)) u_ch (
            .clock      (clock),
            .resetn     (resetn),
            .en         (en[g]),
            .sync       (sync),
            .wr         (xfer && (cfg_ch == CW'(g))),
            .wr_m       (cfg_m),
`ifdef CLKDIV_DUTY_EN
            .wr_h       (cfg_h),
`endif
            .pending    (pending[g]),
            .slow_clock (slow_clock[g]),
            .rise_tick  (rise_tick[g])
        );
    end

endmodule

// File: tb/tb_multi_clk_divider.sv
// Self-checking bench for multi_clk_divider: period-position reference model plus directed scenarios.
// Honours CLKDIV_DUTY_EN when defined.
module tb_multi_clk_divider;

    localparam int unsigned NCH   = 4;
    localparam int unsigned WIDTH = 4;

    logic             clock = 1'b0;
    logic             resetn;
    logic [NCH-1:0]   en;
    logic             sync;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [1:0]       cfg_ch;
    logic [WIDTH-1:0] cfg_m;
`ifdef CLKDIV_DUTY_EN
    logic [WIDTH-1:0] cfg_h;
`endif
    logic [NCH-1:0]   slow_clock;
    logic [NCH-1:0]   rise_tick;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    multi_clk_divider #(.NCH(NCH), .WIDTH(WIDTH)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .en         (en),
        .sync       (sync),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_m      (cfg_m),
`ifdef CLKDIV_DUTY_EN
        .cfg_h      (cfg_h),
`endif
        .slow_clock (slow_clock),
        .rise_tick  (rise_tick)
    );

    always #5 clock = ~clock;

    // Reference model: each running channel is a position within a period of
    // (h+1)+(m+1) cycles; the first h+1 positions are high.
    int unsigned m_act_m [NCH];
    int unsigned m_act_h [NCH];
    int unsigned m_sh_m  [NCH];
    int unsigned m_sh_h  [NCH];
    int unsigned m_pos   [NCH];
    bit          m_pend  [NCH];
    bit          m_run   [NCH];

    always @(posedge clock) begin
        int unsigned per;
        bit bnd, cm, wr;
        for (int i = 0; i < NCH; i++) begin
            if (!resetn) begin
                m_act_m[i] = 0; m_act_h[i] = 0; m_sh_m[i] = 0; m_sh_h[i] = 0;
                m_pos[i] = 0; m_pend[i] = 0; m_run[i] = 0;
            end else begin
                wr  = cfg_valid && (int'(cfg_ch) == i) && !m_pend[i];
                per = m_act_h[i] + m_act_m[i] + 2;
                bnd = m_run[i] && (m_pos[i] == per - 1);
                cm  = m_pend[i] && (!en[i] || sync || !m_run[i] || bnd);
                if (cm) begin
                    m_act_m[i] = m_sh_m[i];
`ifdef CLKDIV_DUTY_EN
                    m_act_h[i] = m_sh_h[i];
`else
                    m_act_h[i] = m_sh_m[i];
`endif
                    m_pend[i] = 0;
                end
                if (wr) begin
                    m_sh_m[i] = int'(cfg_m);
`ifdef CLKDIV_DUTY_EN
                    m_sh_h[i] = int'(cfg_h);
`endif
                    m_pend[i] = 1;
                end
                if (!en[i]) begin
                    m_run[i] = 0;
                    m_pos[i] = 0;
                end else if (sync || !m_run[i] || bnd) begin
                    m_run[i] = 1;
                    m_pos[i] = 0;
                end else begin
                    m_pos[i] = m_pos[i] + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock and compare every output with the model.
    task automatic tick();
        logic [NCH-1:0] es, er;
        @(posedge clock);
        #1;
        for (int i = 0; i < NCH; i++) begin
            es[i] = m_run[i] && (m_pos[i] <= m_act_h[i]);
            er[i] = m_run[i] && (m_pos[i] == 0);
        end
        check("slow_clock", 32'(slow_clock), 32'(es));
        check("rise_tick",  32'(rise_tick),  32'(er));
        check("cfg_ready",  32'(cfg_ready),  32'(!m_pend[int'(cfg_ch)]));
    endtask

    task automatic write_cfg(input int ch, input int m, input int h);
        cfg_valid = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_m     = WIDTH'(m);
`ifdef CLKDIV_DUTY_EN
        cfg_h     = WIDTH'(h);
`else
        if (h < 0) cfg_m = '0;
`endif
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        int idx;
        resetn = 1'b0; en = '0; sync = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_m = '0;
`ifdef CLKDIV_DUTY_EN
        cfg_h = '0;
`endif
        do_reset();
        check("rst_slow",  32'(slow_clock), 32'(0));
        check("rst_rise",  32'(rise_tick),  32'(0));
        check("rst_ready", 32'(cfg_ready),  32'(1));

        // Divide-by-two on channel 0.
        write_cfg(0, 0, 0);
        en = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("div2_slow", 32'(slow_clock[0]), 32'((k % 2) == 0));
            check("div2_rise", 32'(rise_tick[0]),  32'((k % 2) == 0));
        end

        // Reconfigure a running channel; ready stays low until its boundary.
        write_cfg(1, 1, 1);
        en = 4'b0011;
        for (int k = 0; k < 5; k++) tick();
        write_cfg(1, 3, 3);
        check("reconf_ready", 32'(cfg_ready), 32'(0));
        for (int k = 0; k < 24; k++) tick();

`ifdef CLKDIV_DUTY_EN
        write_cfg(3, 4, 0);
        en = 4'b1011;
        for (int k = 0; k < 18; k++) tick();
`endif

        // Out-of-phase channels 0 and 2 aligned by sync.
        write_cfg(2, 2, 2);
        en = en | 4'b0101;
        for (int k = 0; k < 3; k++) tick();
        write_cfg(0, 5, 5);
        for (int k = 0; k < 3; k++) tick();
        sync = 1'b1;
        tick();
        sync = 1'b0;
        check("sync_slow", 32'(slow_clock & 4'b0101), 32'(4'b0101));
        check("sync_rise", 32'(rise_tick & 4'b0101),  32'(4'b0101));
        for (int k = 0; k < 6; k++) tick();

        // Drop en[0] mid-HIGH while a config is pending.
        write_cfg(0, 7, 7);
        sync = 1'b1;
        tick();
        sync = 1'b0;
        tick();
        write_cfg(0, 2, 2);
        en[0] = 1'b0;
        tick();
        check("endrop_slow",  32'(slow_clock[0]), 32'(0));
        check("endrop_ready", 32'(cfg_ready),     32'(1));

        // Reset mid-LOW with a pending config.
        en[0] = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        write_cfg(0, 9, 9);
        for (int k = 0; k < 40 && !(m_run[0] && m_pos[0] > m_act_h[0]); k++) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check("rstmid_slow",  32'(slow_clock), 32'(0));
        check("rstmid_rise",  32'(rise_tick),  32'(0));
        check("rstmid_ready", 32'(cfg_ready),  32'(1));
        en = '0;
        tick();
        en = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rstmid_div2", 32'(slow_clock[0]), 32'((k % 2) == 0));
        end

        // Randomized traffic, including all-ones cutoffs.
        for (int n = 0; n < 3000; n++) begin
            resetn = ($urandom_range(0, 399) != 0);
            if ($urandom_range(0, 19) == 0) begin
                idx = int'($urandom_range(0, NCH - 1));
                en[idx] = ~en[idx];
            end
            sync      = ($urandom_range(0, 59) == 0);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_ch    = 2'($urandom_range(0, 3));
            cfg_m     = ($urandom_range(0, 7) == 0) ? '1 : WIDTH'($urandom_range(0, 5));
`ifdef CLKDIV_DUTY_EN
            cfg_h     = ($urandom_range(0, 7) == 0) ? '1 : WIDTH'($urandom_range(0, 5));
`endif
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
